// File: rtl/coef_write_sequencer.sv
// coef_write_sequencer
//   Takes host coefficient / EQ-gain write strobes (from the SPI register block), latches the
//   data and issues single-cycle writes into the FIR coefficient RAM and the EQ gain table.
//   A RAM write is only granted in a cycle where the FIR engine does not own the RAM
//   (fir_busy low), so audio processing is never stalled.
//   The tap address auto-increments per filter and wraps at the programmed tap count.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   coef_wr_stb             pulse: write {coef_msb,coef_lsb} to the next tap of filter_sel
//   eq_wr_stb               pulse: write {eq_msb,eq_lsb} as gain of filter_sel
//   filter_sel              selected filter (must be < NUM_FILTERS)
//   taps_per_filt           taps per filter, 0 means 2**TAP_BITS
//   fir_busy                FIR engine owns the coef RAM this cycle
//   clr_err                 pulse: clear sticky error flags
//   coef_we/addr/wdata      coef RAM write port, addr = {filter, tap}
//   eq_we/addr/wdata        EQ gain table write port
//   tap_index               next tap to be written
//   busy                    a write is pending or in progress
//   err_overrun, err_range  sticky error flags
module coef_write_sequencer #(
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned FILT_BITS   = 2,
  parameter int unsigned TAP_BITS    = 8,
  parameter int unsigned COEF_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          coef_wr_stb,
  input  logic                          eq_wr_stb,
  input  logic [7:0]                    filter_sel,
  input  logic [7:0]                    taps_per_filt,
  input  logic [7:0]                    coef_lsb,
  input  logic [7:0]                    coef_msb,
  input  logic [7:0]                    eq_lsb,
  input  logic [7:0]                    eq_msb,
  input  logic                          fir_busy,
  input  logic                          clr_err,
  output logic                          coef_we,
  output logic [FILT_BITS+TAP_BITS-1:0] coef_addr,
  output logic [COEF_W-1:0]             coef_wdata,
  output logic                          eq_we,
  output logic [FILT_BITS-1:0]          eq_addr,
  output logic [COEF_W-1:0]             eq_wdata,
  output logic [TAP_BITS-1:0]           tap_index,
  output logic                          busy,
  output logic                          err_overrun,
  output logic                          err_range
);

  typedef enum logic [1:0] {StIdle, StGrant, StWrite} state_e;

  localparam logic [7:0] NumFiltSel = 8'(NUM_FILTERS);

  state_e                          state_q, state_d;
  logic                            coef_pend_q, coef_pend_d, eq_pend_q, eq_pend_d;
  logic [COEF_W-1:0]               coef_data_q, eq_data_q;
  logic [FILT_BITS-1:0]            coef_filt_q, eq_filt_q;
  logic [TAP_BITS-1:0]             tap_q, tap_d, last_tap;
  logic                            err_overrun_q, err_overrun_d, err_range_q, err_range_d;
  logic                            coef_we_q, coef_we_d, eq_we_q, eq_we_d;
  logic [FILT_BITS+TAP_BITS-1:0]   coef_addr_q, coef_addr_d;
  logic [COEF_W-1:0]               coef_wdata_q, coef_wdata_d, eq_wdata_q, eq_wdata_d;
  logic [FILT_BITS-1:0]            eq_addr_q, eq_addr_d;

  logic                 in_range, writing_coef, writing_eq, coef_ok, eq_ok;
  logic                 range_ev, overrun_ev;
  logic [FILT_BITS-1:0] sel_filt;

  assign sel_filt     = filter_sel[FILT_BITS-1:0];
  assign in_range     = filter_sel < NumFiltSel;
  assign writing_coef = (state_q == StWrite) && coef_we_q;
  assign writing_eq   = (state_q == StWrite) && eq_we_q;
  // A same-type strobe in the write cycle of that type is accepted: the slot frees this cycle.
  assign coef_ok      = coef_wr_stb && in_range && (!coef_pend_q || writing_coef);
  assign eq_ok        = eq_wr_stb && in_range && (!eq_pend_q || writing_eq);
  assign range_ev     = (coef_wr_stb || eq_wr_stb) && !in_range;
  assign overrun_ev   = (coef_wr_stb && in_range && !coef_ok) ||
                        (eq_wr_stb && in_range && !eq_ok);
  // taps_per_filt == 0 underflows to all-ones, i.e. wrap at 2**TAP_BITS-1.
  assign last_tap     = taps_per_filt[TAP_BITS-1:0] - TAP_BITS'(1);

  always_comb begin
    coef_pend_d   = coef_pend_q;
    eq_pend_d     = eq_pend_q;
    tap_d         = tap_q;
    err_range_d   = range_ev | (err_range_q & ~clr_err);
    err_overrun_d = overrun_ev | (err_overrun_q & ~clr_err);

    if (writing_coef) coef_pend_d = 1'b0;
    if (writing_eq)   eq_pend_d   = 1'b0;
    if (coef_ok)      coef_pend_d = 1'b1;
    if (eq_ok)        eq_pend_d   = 1'b1;

    // ">=" also covers a tap count lowered below the current tap.
    if (writing_coef) tap_d = (tap_q >= last_tap) ? '0 : tap_q + TAP_BITS'(1);
    if (coef_ok && (sel_filt != coef_filt_q)) tap_d = '0;
  end

  always_comb begin
    state_d      = state_q;
    coef_we_d    = 1'b0;
    eq_we_d      = 1'b0;
    coef_addr_d  = coef_addr_q;
    coef_wdata_d = coef_wdata_q;
    eq_addr_d    = eq_addr_q;
    eq_wdata_d   = eq_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (coef_pend_d || eq_pend_d) state_d = StGrant;
      end
      StGrant: begin
        if (!fir_busy && (coef_pend_q || eq_pend_q)) begin
          state_d = StWrite;
          if (coef_pend_q) begin
            coef_we_d    = 1'b1;
            coef_addr_d  = {coef_filt_q, tap_q};
            coef_wdata_d = coef_data_q;
          end else begin
            eq_we_d    = 1'b1;
            eq_addr_d  = eq_filt_q;
            eq_wdata_d = eq_data_q;
          end
        end
      end
      StWrite: begin
        // Remaining work goes straight into the next grant pass without an idle bubble.
        state_d = (coef_pend_d || eq_pend_d) ? StGrant : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      coef_pend_q   <= 1'b0;
      eq_pend_q     <= 1'b0;
      coef_data_q   <= '0;
      eq_data_q     <= '0;
      coef_filt_q   <= '0;
      eq_filt_q     <= '0;
      tap_q         <= '0;
      err_overrun_q <= 1'b0;
      err_range_q   <= 1'b0;
      coef_we_q     <= 1'b0;
      eq_we_q       <= 1'b0;
      coef_addr_q   <= '0;
      coef_wdata_q  <= '0;
      eq_addr_q     <= '0;
      eq_wdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      coef_pend_q   <= coef_pend_d;
      eq_pend_q     <= eq_pend_d;
      tap_q         <= tap_d;
      err_overrun_q <= err_overrun_d;
      err_range_q   <= err_range_d;
      coef_we_q     <= coef_we_d;
      eq_we_q       <= eq_we_d;
      coef_addr_q   <= coef_addr_d;
      coef_wdata_q  <= coef_wdata_d;
      eq_addr_q     <= eq_addr_d;
      eq_wdata_q    <= eq_wdata_d;
      if (coef_ok) begin
        coef_data_q <= COEF_W'({coef_msb, coef_lsb});
        coef_filt_q <= sel_filt;
      end
      if (eq_ok) begin
        eq_data_q <= COEF_W'({eq_msb, eq_lsb});
        eq_filt_q <= sel_filt;
      end
    end
  end

  assign coef_we     = coef_we_q;
  assign coef_addr   = coef_addr_q;
  assign coef_wdata  = coef_wdata_q;
  assign eq_we       = eq_we_q;
  assign eq_addr     = eq_addr_q;
  assign eq_wdata    = eq_wdata_q;
  assign tap_index   = tap_q;
  assign busy        = coef_pend_q | eq_pend_q | (state_q != StIdle);
  assign err_overrun = err_overrun_q;
  assign err_range   = err_range_q;

endmodule

// File: tb/tb_coef_write_sequencer.sv
// Directed bench for coef_write_sequencer with hand-computed expectations.
module tb_coef_write_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        coef_wr_stb, eq_wr_stb, fir_busy, clr_err;
  logic [7:0]  filter_sel, taps_per_filt, coef_lsb, coef_msb, eq_lsb, eq_msb;
  logic        coef_we, eq_we, busy, err_overrun, err_range;
  logic [9:0]  coef_addr;
  logic [15:0] coef_wdata, eq_wdata;
  logic [1:0]  eq_addr;
  logic [7:0]  tap_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coef_write_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coef_wr_stb  (coef_wr_stb),
    .eq_wr_stb    (eq_wr_stb),
    .filter_sel   (filter_sel),
    .taps_per_filt(taps_per_filt),
    .coef_lsb     (coef_lsb),
    .coef_msb     (coef_msb),
    .eq_lsb       (eq_lsb),
    .eq_msb       (eq_msb),
    .fir_busy     (fir_busy),
    .clr_err      (clr_err),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .eq_we        (eq_we),
    .eq_addr      (eq_addr),
    .eq_wdata     (eq_wdata),
    .tap_index    (tap_index),
    .busy         (busy),
    .err_overrun  (err_overrun),
    .err_range    (err_range)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one coef strobe cycle, leaves the bench one cycle after the strobe.
  task automatic coef_pulse(input logic [7:0] filt, input logic [15:0] data);
    filter_sel  = filt;
    coef_msb    = data[15:8];
    coef_lsb    = data[7:0];
    coef_wr_stb = 1'b1;
    step();
    coef_wr_stb = 1'b0;
  endtask

  // Strobe, then expect the write exactly two cycles after it and the tap update one later.
  task automatic coef_write(input logic [7:0] filt, input logic [15:0] data,
                            input logic [9:0] exp_addr, input logic [7:0] exp_tap);
    coef_pulse(filt, data);
    check("we_n1", 32'(coef_we), 32'd0);
    check("busy_n1", 32'(busy), 32'd1);
    step();
    check("we_n2", 32'(coef_we), 32'd1);
    check("addr", 32'(coef_addr), 32'(exp_addr));
    check("wdata", 32'(coef_wdata), 32'(data));
    step();
    check("we_n3", 32'(coef_we), 32'd0);
    check("tap", 32'(tap_index), 32'(exp_tap));
  endtask

  initial begin
    reset_n = 1'b0; coef_wr_stb = 1'b0; eq_wr_stb = 1'b0; fir_busy = 1'b0; clr_err = 1'b0;
    filter_sel = 8'd0; taps_per_filt = 8'd4; coef_lsb = 8'd0; coef_msb = 8'd0;
    eq_lsb = 8'd0; eq_msb = 8'd0;
    step();
    step();
    check("rst_coef_we", 32'(coef_we), 32'd0);
    check("rst_eq_we", 32'(eq_we), 32'd0);
    check("rst_addr", 32'(coef_addr), 32'd0);
    check("rst_tap", 32'(tap_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", 32'({err_overrun, err_range}), 32'd0);
    reset_n = 1'b1;
    step();

    // 1: taps=4, filter 1, five writes wrap back to tap 0
    for (int i = 0; i < 5; i++) begin
      coef_write(8'd1, 16'h1234 + 16'(i), 10'h100 + 10'(i % 4), 8'((i + 1) % 4));
    end

    // 2: fir_busy held high for 10 cycles starting with the strobe
    fir_busy = 1'b1;
    coef_pulse(8'd1, 16'hBEEF);
    for (int k = 0; k < 9; k++) begin
      check("busy_hold_we", 32'(coef_we), 32'd0);
      check("busy_hold_busy", 32'(busy), 32'd1);
      step();
    end
    fir_busy = 1'b0;
    check("busy_fall_we", 32'(coef_we), 32'd0);
    step();
    check("busy_late_we", 32'(coef_we), 32'd1);
    check("busy_late_addr", 32'(coef_addr), 32'h101);
    check("busy_late_data", 32'(coef_wdata), 32'hBEEF);
    step();

    // 3: coef and eq together on filter 2: coef first, eq two cycles later
    filter_sel = 8'd2; coef_msb = 8'hC0; coef_lsb = 8'hDE; eq_msb = 8'h0A; eq_lsb = 8'h0B;
    coef_wr_stb = 1'b1; eq_wr_stb = 1'b1;
    step();
    coef_wr_stb = 1'b0; eq_wr_stb = 1'b0;
    step();
    check("both_coef_we", 32'(coef_we), 32'd1);
    check("both_eq_we0", 32'(eq_we), 32'd0);
    check("both_coef_addr", 32'(coef_addr), 32'h200);
    step();
    check("both_gap", 32'({coef_we, eq_we}), 32'd0);
    step();
    check("both_eq_we", 32'(eq_we), 32'd1);
    check("both_eq_addr", 32'(eq_addr), 32'd2);
    check("both_eq_data", 32'(eq_wdata), 32'h0A0B);
    check("both_coef_we1", 32'(coef_we), 32'd0);
    step();
    check("both_idle", 32'(busy), 32'd0);

    // 4: filter 0 three writes, switch to filter 3, then an out-of-range filter
    for (int i = 0; i < 3; i++) begin
      coef_write(8'd0, 16'h0100 + 16'(i), 10'(i), 8'(i + 1));
    end
    coef_write(8'd3, 16'h3333, 10'h300, 8'd1);
    coef_pulse(8'd5, 16'hDEAD);
    check("range_err", 32'(err_range), 32'd1);
    check("range_busy", 32'(busy), 32'd0);
    step();
    check("range_no_we", 32'(coef_we), 32'd0);
    check("range_tap", 32'(tap_index), 32'd1);
    clr_err = 1'b1;
    coef_pulse(8'd7, 16'hDEAD);
    check("range_err_wins", 32'(err_range), 32'd1);
    step();
    clr_err = 1'b0;
    check("range_clr", 32'(err_range), 32'd0);

    // 5: second strobe while the first is still pending is dropped
    fir_busy = 1'b1;
    coef_pulse(8'd3, 16'h1111);
    step();
    coef_pulse(8'd3, 16'h2222);
    check("ovr_err", 32'(err_overrun), 32'd1);
    fir_busy = 1'b0;
    step();
    check("ovr_we", 32'(coef_we), 32'd1);
    check("ovr_data", 32'(coef_wdata), 32'h1111);
    check("ovr_addr", 32'(coef_addr), 32'h301);
    step();
    check("ovr_single_we", 32'(coef_we), 32'd0);
    check("ovr_busy", 32'(busy), 32'd0);

    // 6: reset while a write sits in GRANT (overrun flag still set from test 5)
    fir_busy = 1'b1;
    coef_pulse(8'd3, 16'h5555);
    check("rst_mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    fir_busy = 1'b0;
    check("rst_mid_we", 32'(coef_we), 32'd0);
    check("rst_mid_tap", 32'(tap_index), 32'd0);
    check("rst_mid_flags", 32'({busy, err_overrun, err_range}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst_mid_no_we", 32'({coef_we, eq_we}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
